// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave controller.
package i2c_slave_pkg;

    // Transaction sequencer states; RW through TX_ACK mean the slave is addressed.
    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        RW,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } i2c_state_t;

    localparam int ADDR_BITS = 7;
    localparam int BYTE_BITS = 8;
    localparam int BIT_CNT_W = $clog2(BYTE_BITS);

    // Counter value while the last bit of a byte is on the bus.
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_BITS - 1);

endpackage

// File: rtl/i2c_slave_controller_counter.sv
// Free-running up counter with synchronous clear, used as the bit counter.
module i2c_slave_controller_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Synchronous clear wins over counting; the count wraps at 2**WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/i2c_slave_controller.sv
// I2C slave transaction sequencer: pin sync, START/STOP detection, address
// handshake with the external decoder, byte receive/transmit and ACK cycles.
// Owns the open-drain SDA drive (sda_oe=1 pulls the line low).
module i2c_slave_controller
    import i2c_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 FPGA_clk,
    input  logic                 rst,
    input  logic                 SCL,
    input  logic                 SDA,
    output logic                 SCL_sync,
    output logic                 SDA_sync,
    output logic                 SCL_prev,
    output logic                 dec_enable,
    output logic                 dec_rst,
    input  logic                 dec_done,
    input  logic                 dec_selected,
    output logic                 sda_oe,
    output logic                 rw,
    output logic [BYTE_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic [BYTE_BITS-1:0] tx_data,
    output logic                 tx_req,
    output logic                 busy,
    output i2c_state_t           state
);

    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   sda_prev;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   bit_cnt_clr;
    logic                   bit_cnt_en;
    logic [BYTE_BITS-1:0]   shift_reg;
    logic                   master_ack;

    // Pin synchronizers plus one-cycle history; all reset to the idle-bus level.
    always_ff @(posedge FPGA_clk or negedge rst) begin
        if (!rst) begin
            scl_ff   <= '1;
            sda_ff   <= '1;
            SCL_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_ff   <= {scl_ff[SYNC_STAGES-2:0], SCL};
            sda_ff   <= {sda_ff[SYNC_STAGES-2:0], SDA};
            SCL_prev <= scl_ff[SYNC_STAGES-1];
            sda_prev <= sda_ff[SYNC_STAGES-1];
        end
    end

    assign SCL_sync  = scl_ff[SYNC_STAGES-1];
    assign SDA_sync  = sda_ff[SYNC_STAGES-1];
    assign scl_rise  = SCL_sync & ~SCL_prev;
    assign scl_fall  = ~SCL_sync & SCL_prev;
    assign start_det = SCL_sync & sda_prev & ~SDA_sync;
    assign stop_det  = SCL_sync & ~sda_prev & SDA_sync;

    // Held at zero outside the byte states, so it starts from 0 on every entry.
    assign bit_cnt_clr = (state != RX_BYTE) && (state != TX_BYTE);
    // Receive counts rising edges, transmit counts falling edges.
    assign bit_cnt_en  = ((state == RX_BYTE) && scl_rise) ||
                         ((state == TX_BYTE) && scl_fall);

    i2c_slave_controller_counter #(
        .WIDTH (BIT_CNT_W)
    ) u_bit_cnt (
        .clk   (FPGA_clk),
        .rst   (~rst | bit_cnt_clr),
        .en    (bit_cnt_en),
        .count (bit_cnt)
    );

    // Sequencer: state, SDA drive and all handshake strobes are registered here.
    always_ff @(posedge FPGA_clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sda_oe     <= 1'b0;
            dec_enable <= 1'b0;
            dec_rst    <= 1'b0;
            rw         <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
            busy       <= 1'b0;
            shift_reg  <= '0;
            master_ack <= 1'b0;
        end else begin
            dec_rst  <= 1'b0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (start_det) begin
                // START (first or repeated) beats any coincident SCL edge; rw is kept.
                state      <= ADDR;
                dec_rst    <= 1'b1;
                dec_enable <= 1'b1;
                busy       <= 1'b0;
                sda_oe     <= 1'b0;
            end else if (stop_det) begin
                state      <= IDLE;
                dec_enable <= 1'b0;
                busy       <= 1'b0;
                sda_oe     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    ADDR: begin
                        // dec_done is stale during the dec_rst cycle, so ignore it there.
                        if (dec_done && !dec_rst) begin
                            dec_enable <= 1'b0;
                            if (dec_selected) begin
                                state <= RW;
                                busy  <= 1'b1;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    RW: begin
                        if (scl_rise) begin
                            rw    <= SDA_sync;
                            state <= ADDR_ACK;
                        end
                    end
                    ADDR_ACK: begin
                        // sda_oe doubles as the phase flag: first fall drives, second releases.
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else if (!rw) begin
                                sda_oe <= 1'b0;
                                state  <= RX_BYTE;
                            end else begin
                                tx_req    <= 1'b1;
                                shift_reg <= tx_data;
                                sda_oe    <= ~tx_data[BYTE_BITS-1];
                                state     <= TX_BYTE;
                            end
                        end
                    end
                    RX_BYTE: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[BYTE_BITS-2:0], SDA_sync};
                            if (bit_cnt == LAST_BIT) begin
                                rx_data  <= {shift_reg[BYTE_BITS-2:0], SDA_sync};
                                rx_valid <= 1'b1;
                                state    <= RX_ACK;
                            end
                        end
                    end
                    RX_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= RX_BYTE;
                            end
                        end
                    end
                    TX_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == LAST_BIT) begin
                                sda_oe     <= 1'b0;
                                master_ack <= 1'b0;
                                state      <= TX_ACK;
                            end else begin
                                // Rotate so the next bit sits in the MSB position.
                                shift_reg <= {shift_reg[BYTE_BITS-2:0], shift_reg[BYTE_BITS-1]};
                                sda_oe    <= ~shift_reg[BYTE_BITS-2];
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (!SDA_sync) begin
                                master_ack <= 1'b1;
                            end else begin
                                state <= WAIT_STOP;
                                busy  <= 1'b0;
                            end
                        end else if (scl_fall && master_ack) begin
                            tx_req    <= 1'b1;
                            shift_reg <= tx_data;
                            sda_oe    <= ~tx_data[BYTE_BITS-1];
                            state     <= TX_BYTE;
                        end
                    end
                    WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Bench for the I2C slave controller: bit-banged master, behavioural address
// decoder at 0x42, scoreboard queues checked by monitor processes.
`timescale 1ns/1ps
module tb_i2c_slave_controller;
    import i2c_slave_pkg::*;

    localparam int Q = 6;  // quarter SCL period in FPGA_clk cycles

    logic       FPGA_clk = 1'b0;
    logic       rst      = 1'b0;
    logic       scl_pin  = 1'b1;
    logic       sda_m    = 1'b1;
    logic       sda_line;
    logic       SCL_sync, SDA_sync, SCL_prev;
    logic       dec_enable, dec_rst, dec_done, dec_selected;
    logic       sda_oe, rw, rx_valid, tx_req, busy;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;
    i2c_state_t state;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_rd_q[$];
    logic [0:0] exp_ack_q[$];
    logic [7:0] tx_src_q[$];

    event       rd_ev;
    event       ack_ev;
    logic [7:0] rd_byte;
    logic       ack_bit;

    int   rxv_cnt = 0;
    int   tx_cnt = 0;
    int   dec_rst_cnt = 0;
    logic oe_seen = 1'b0;
    logic idle_seen = 1'b0;
    logic rx_valid_d = 1'b0;
    logic tx_req_d = 1'b0;

    logic [2:0] dcnt;
    logic [6:0] dshift;

    always #5 FPGA_clk = ~FPGA_clk;

    // Open-drain wire-AND of master and slave.
    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_controller #(.SYNC_STAGES(2)) dut (
        .FPGA_clk     (FPGA_clk),
        .rst          (rst),
        .SCL          (scl_pin),
        .SDA          (sda_line),
        .SCL_sync     (SCL_sync),
        .SDA_sync     (SDA_sync),
        .SCL_prev     (SCL_prev),
        .dec_enable   (dec_enable),
        .dec_rst      (dec_rst),
        .dec_done     (dec_done),
        .dec_selected (dec_selected),
        .sda_oe       (sda_oe),
        .rw           (rw),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_req       (tx_req),
        .busy         (busy),
        .state        (state)
    );

    // Address decoder stand-in: own address 0x42, shifts 7 bits on rising SCL.
    always @(posedge FPGA_clk or negedge rst) begin
        if (!rst) begin
            dcnt   <= 3'd0;
            dshift <= 7'd0;
        end else if (dec_rst) begin
            dcnt   <= 3'd0;
            dshift <= 7'd0;
        end else if (dec_enable && SCL_sync && !SCL_prev && dcnt != 3'd7) begin
            dshift <= {dshift[5:0], SDA_sync};
            dcnt   <= dcnt + 3'd1;
        end
    end
    assign dec_done     = (dcnt == 3'd7);
    assign dec_selected = (dshift == 7'h42);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: strobes, pulse widths and sticky observation flags.
    always @(negedge FPGA_clk) begin
        if (rst) begin
            if (rx_valid) begin
                rxv_cnt++;
                check("rx_valid_single_cycle", {31'd0, rx_valid_d}, 32'd0);
                if (exp_rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %02h expected no byte", rx_data);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
                end
            end
            if (tx_req) begin
                tx_cnt++;
                check("tx_req_single_cycle", {31'd0, tx_req_d}, 32'd0);
                if (tx_src_q.size() != 0) tx_data = tx_src_q.pop_front();
            end
            if (dec_rst) dec_rst_cnt++;
            if (sda_oe) oe_seen = 1'b1;
            if (state == IDLE) idle_seen = 1'b1;
        end
        rx_valid_d = rx_valid;
        tx_req_d   = tx_req;
    end

    // Monitor: bytes read by the master off SDA.
    initial begin
        forever begin
            @(rd_ev);
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %02h expected no byte", rd_byte);
            end else begin
                check("rd_byte", {24'd0, rd_byte}, {24'd0, exp_rd_q.pop_front()});
            end
        end
    end

    // Monitor: ACK bit seen by the master after each byte it sends.
    initial begin
        forever begin
            @(ack_ev);
            if (exp_ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack_unexpected: got %0b expected none", ack_bit);
            end else begin
                check("ack_bit", {31'd0, ack_bit}, {31'd0, exp_ack_q.pop_front()});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_q();
        repeat (Q) @(negedge FPGA_clk);
    endtask

    task automatic settle();
        repeat (4) @(negedge FPGA_clk);
    endtask

    task automatic write_bit(input logic b);
        wait_q(); sda_m = b;
        wait_q(); scl_pin = 1'b1;
        wait_q(); wait_q(); scl_pin = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_q(); sda_m = 1'b1;
        wait_q(); scl_pin = 1'b1;
        wait_q(); b = sda_line;
        wait_q(); scl_pin = 1'b0;
    endtask

    task automatic i2c_start();
        wait_q(); sda_m = 1'b1;
        wait_q(); scl_pin = 1'b1;
        wait_q(); sda_m = 1'b0;
        wait_q(); scl_pin = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q(); sda_m = 1'b0;
        wait_q(); scl_pin = 1'b1;
        wait_q(); sda_m = 1'b1;
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack);
        logic a;
        exp_ack_q.push_back(exp_ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(a);
        ack_bit = a;
        -> ack_ev;
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic m_ack);
        logic [7:0] v;
        logic       bb;
        v = 8'h00;
        exp_rd_q.push_back(exp);
        for (int i = 0; i < 8; i++) begin
            read_bit(bb);
            v = {v[6:0], bb};
        end
        rd_byte = v;
        -> rd_ev;
        write_bit(m_ack);
    endtask

    initial begin
        int rxv_before;

        // Reset values
        repeat (3) @(negedge FPGA_clk);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_dec_enable", {31'd0, dec_enable}, 32'd0);
        check("rst_dec_rst", {31'd0, dec_rst}, 32'd0);
        check("rst_rw", {31'd0, rw}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_strobes", {30'd0, rx_valid, tx_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", state, IDLE);
        check("rst_sync", {29'd0, SCL_sync, SDA_sync, SCL_prev}, 32'd7);
        rst = 1'b1;
        repeat (4) @(negedge FPGA_clk);

        // Write 0xA5 to 0x42
        i2c_start();
        settle();
        check("t1_dec_enable", {31'd0, dec_enable}, 32'd1);
        check("t1_state_addr", state, ADDR);
        send_byte(8'h84, 1'b0);
        settle();
        check("t1_state_rx", state, RX_BYTE);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_rw", {31'd0, rw}, 32'd0);
        check("t1_dec_enable_off", {31'd0, dec_enable}, 32'd0);
        exp_rx_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b0);
        i2c_stop();
        check("t1_state_idle", state, IDLE);
        check("t1_busy_off", {31'd0, busy}, 32'd0);

        // Unmatched address 0x43, then STOP and a matched transfer
        oe_seen = 1'b0;
        i2c_start();
        send_byte(8'h86, 1'b1);
        settle();
        check("t2_state_wait", state, WAIT_STOP);
        send_byte(8'h00, 1'b1);
        settle();
        check("t2_still_wait", state, WAIT_STOP);
        check("t2_busy", {31'd0, busy}, 32'd0);
        check("t2_no_oe", {31'd0, oe_seen}, 32'd0);
        i2c_stop();
        check("t2_idle", state, IDLE);
        i2c_start();
        send_byte(8'h84, 1'b0);
        exp_rx_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b0);
        i2c_stop();

        // Read 0x3C (master ACK) then 0xC3 (master NACK)
        tx_cnt = 0;
        tx_data = 8'h3C;
        tx_src_q.push_back(8'hC3);
        i2c_start();
        send_byte(8'h85, 1'b0);
        read_byte(8'h3C, 1'b0);
        check("t3_rw", {31'd0, rw}, 32'd1);
        read_byte(8'hC3, 1'b1);
        settle();
        check("t3_state_wait", state, WAIT_STOP);
        check("t3_tx_req_count", tx_cnt, 32'd2);
        check("t3_sda_released", {31'd0, sda_oe}, 32'd0);
        i2c_stop();

        // Write 0x11 then repeated START into a read
        i2c_start();
        send_byte(8'h84, 1'b0);
        exp_rx_q.push_back(8'h11);
        send_byte(8'h11, 1'b0);
        check("t4_rw_write", {31'd0, rw}, 32'd0);
        idle_seen = 1'b0;
        dec_rst_cnt = 0;
        tx_data = 8'h3C;
        i2c_start();
        settle();
        check("t4_rw_kept", {31'd0, rw}, 32'd0);
        send_byte(8'h85, 1'b0);
        check("t4_rw_read", {31'd0, rw}, 32'd1);
        check("t4_dec_rst_pulses", dec_rst_cnt, 32'd1);
        check("t4_no_idle", {31'd0, idle_seen}, 32'd0);
        read_byte(8'h3C, 1'b1);
        i2c_stop();

        // STOP after 4 bits of a received byte
        i2c_start();
        send_byte(8'h84, 1'b0);
        rxv_before = rxv_cnt;
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        i2c_stop();
        check("t5_state_idle", state, IDLE);
        check("t5_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_no_rx_valid", rxv_cnt - rxv_before, 32'd0);
        check("t5_rx_data_kept", {24'd0, rx_data}, 32'h11);

        // Reset while the slave drives the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(8'h84 >> i);
        wait_q(); sda_m = 1'b1;
        wait_q(); scl_pin = 1'b1;
        wait_q();
        check("t6_ack_driven", {31'd0, sda_oe}, 32'd1);
        check("t6_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("t6_sda_oe_async", {31'd0, sda_oe}, 32'd0);
        check("t6_busy_async", {31'd0, busy}, 32'd0);
        check("t6_state_async", state, IDLE);
        check("t6_rx_data_async", {24'd0, rx_data}, 32'd0);
        check("t6_rw_dec_async", {29'd0, rw, dec_enable, dec_rst}, 32'd0);
        wait_q();
        rst = 1'b1;
        repeat (10) @(negedge FPGA_clk);
        check("t6_idle_after", state, IDLE);

        check("rx_queue_drained", exp_rx_q.size(), 32'd0);
        check("rd_queue_drained", exp_rd_q.size(), 32'd0);
        check("ack_queue_drained", exp_ack_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
